// File: rtl/seqdiv16.sv
// seqdiv16: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  request, sampled only in IDLE
//   dividend, divisor      operands, captured on the accepting edge
//   busy                   high while iterating
//   done                   one-cycle pulse, results valid from here on
//   quotient, remainder    results, held until the next accepted start
//   div_by_zero            set with done when the captured divisor was 0
module seqdiv16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    // Partial remainder after the shift, WIDTH+1 bits wide.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // The stored remainder is always below the divisor, so rem_sh is below
    // 2*divisor. With that bound the top bit of a WIDTH+1 bit difference is
    // exactly the borrow, and a successful trial always fits in WIDTH bits.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvsr_q};
    assign borrow = trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvsr_d = divisor;
                    quo_d  = dividend;
                    rem_d  = '0;
                    cnt_d  = '0;
                    dbz_d  = 1'b0;
                    if (divisor == '0) begin
                        // Skip iterating; results are fixed by definition.
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (borrow) begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seqdiv16.sv
// tb_seqdiv16: self-checking bench for seqdiv16.
// Directed vectors, handshake/reset sequences and random operands vs a model.
module tb_seqdiv16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seqdiv16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic, divide-by-zero convention applied.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0; lat = W + 1;
        end
    endtask

    // Issue one start and wait (bounded) for done; returns on the done cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt, output int ovl);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        ovl = (busy && done) ? 1 : 0;
    endtask

    task automatic run_check(input string tag,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input int elat);
        int lat, bcnt, ovl;
        logic [31:0] lhs;
        do_op(a, b, lat, bcnt, ovl);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".busycnt"}, bcnt, (elat == 1) ? 0 : W);
        check({tag, ".overlap"}, ovl, 0);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".dbz"}, div_by_zero, edbz);
        if (b != 0) begin
            lhs = quotient * b + remainder;
            check({tag, ".inv"}, (lhs == a && remainder < b) ? 1 : 0, 1);
        end
    endtask

    initial begin
        int lat, bcnt, ovl, nd;
        logic [W-1:0] a, b, mq, mr;
        logic mdbz;
        int mlat;

        tbl[0] = '{16'd100,  16'd7,      16'd14,   16'd2,    1'b0, 17};
        tbl[1] = '{16'hFFFF, 16'd1,      16'hFFFF, 16'd0,    1'b0, 17};
        tbl[2] = '{16'hFFFF, 16'h8000,   16'd1,    16'h7FFF, 1'b0, 17};
        tbl[3] = '{16'd3,    16'd10,     16'd0,    16'd3,    1'b0, 17};
        tbl[4] = '{16'd5,    16'd0,      16'hFFFF, 16'd5,    1'b1, 1};
        tbl[5] = '{16'd0,    16'd5,      16'd0,    16'd0,    1'b0, 17};
        tbl[6] = '{16'd1000, 16'd10,     16'd100,  16'd0,    1'b0, 17};
        tbl[7] = '{16'd0,    16'd0,      16'hFFFF, 16'd0,    1'b1, 1};
        tbl[8] = '{16'hFFFF, 16'hFFFF,   16'd1,    16'd0,    1'b0, 17};
        tbl[9] = '{16'd1,    16'hFFFF,   16'd0,    16'd1,    1'b0, 17};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
                      tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat);
        end

        // Results hold after done
        repeat (3) @(negedge clk);
        check("hold.q", quotient, 16'd0);
        check("hold.r", remainder, 16'd1);
        check("hold.done", done, 0);

        // Start pulsed mid-run is ignored
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (4) begin @(negedge clk); lat++; end
        start = 1'b1; dividend = 16'd7; divisor = 16'd3;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("midstart.lat", lat, 17);
        check("midstart.q", quotient, 16'd100);
        check("midstart.r", remainder, 16'd0);

        // Start held high: re-accepted one cycle after done
        @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("held1.lat", lat, 17);
        check("held1.q", quotient, 16'd10);
        dividend = 16'd77; divisor = 16'd7;
        @(negedge clk);
        check("held.idle_busy", busy, 0);
        check("held.idle_done", done, 0);
        @(negedge clk);
        check("held.reaccept", busy, 1);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("held2.lat", lat, 17);
        check("held2.q", quotient, 16'd11);
        check("held2.r", remainder, 16'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; dividend = 16'd200; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.q", quotient, 0);
        check("midrst.r", remainder, 0);
        check("midrst.dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("midrst.quiet", nd, 0);
        run_check("after_rst", 16'd200, 16'd3, 16'd66, 16'd2, 1'b0, 17);

        // Random regression against the model
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = W'($urandom_range(16'h8000, 16'hFFFF));
                default: b = W'($urandom);
            endcase
            model(a, b, mq, mr, mdbz, mlat);
            run_check($sformatf("rnd%0d", i), a, b, mq, mr, mdbz, mlat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
